// File: rtl/cnn_window_reader.sv
// cnn_window_reader
// Read-side sequencer for the binarized input image RAM. After a start pulse
// it walks every valid 3x3 window in row-major order, reads the nine pixels
// through the RAM's registered read port and presents the assembled window
// to the convolution stage under a valid/ready handshake.
//
// State table:
//   state     | meaning
//   IDLE      | waiting for start
//   FETCH     | issuing the nine tap addresses (tap 0..8)
//   CAPTURE   | last tap's read data lands in win
//   VALID     | window presented, waiting for win_ready
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 one-cycle scan request, sampled only in IDLE
//   rd_addr / rd_data     RAM read port (data one cycle after address)
//   win, win_row, win_col window bits (bit k = tap 3*dr+dc) and its top-left
//   win_valid / win_ready window handshake
//   busy                  high whenever not IDLE
//   done                  one-cycle pulse after the last window is accepted
module cnn_window_reader #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic [8:0]        win,
  output logic [4:0]        win_row,
  output logic [4:0]        win_col,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_VALID
  } state_t;

  localparam logic [4:0]        ROW_LAST = 5'(IMG_H - 3);
  localparam logic [4:0]        COL_LAST = 5'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] ROW1     = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW2     = ADDR_W'(2 * IMG_W);

  state_t            state, state_nxt;
  logic [3:0]        tap;
  logic [3:0]        tap_d;
  logic              cap_en;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] tap_off;
  logic              last_win;

  assign last_win  = (win_row == ROW_LAST) && (win_col == COL_LAST);
  assign busy      = (state != S_IDLE);
  assign win_valid = (state == S_VALID);
  assign rd_addr   = (state == S_FETCH) ? (base + tap_off) : '0;

  // Tap offset dr*IMG_W+dc from constant row strides; no multiplier.
  always_comb begin
    tap_off = '0;
    case (tap)
      4'd0:    tap_off = '0;
      4'd1:    tap_off = ADDR_W'(1);
      4'd2:    tap_off = ADDR_W'(2);
      4'd3:    tap_off = ROW1;
      4'd4:    tap_off = ROW1 + ADDR_W'(1);
      4'd5:    tap_off = ROW1 + ADDR_W'(2);
      4'd6:    tap_off = ROW2;
      4'd7:    tap_off = ROW2 + ADDR_W'(1);
      4'd8:    tap_off = ROW2 + ADDR_W'(2);
      default: tap_off = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_FETCH;
      S_FETCH:   if (tap == 4'd8) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_VALID;
      S_VALID:   if (win_ready) state_nxt = last_win ? S_IDLE : S_FETCH;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tap     <= '0;
      tap_d   <= '0;
      cap_en  <= 1'b0;
      base    <= '0;
      win_row <= '0;
      win_col <= '0;
      win     <= '0;
      done    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done   <= 1'b0;
      // Read data trails its address by one cycle, so the tap index and a
      // capture enable are delayed to line up with rd_data.
      cap_en <= (state == S_FETCH);
      tap_d  <= tap;
      if (cap_en) win[tap_d] <= rd_data;

      case (state)
        S_IDLE: begin
          if (start) begin
            tap     <= '0;
            base    <= '0;
            win_row <= '0;
            win_col <= '0;
          end
        end
        S_FETCH: tap <= tap + 4'd1;
        S_VALID: begin
          if (win_ready) begin
            tap <= '0;
            if (last_win) begin
              done <= 1'b1;
            end else if (win_col == COL_LAST) begin
              // base was row*W + W-3; next row start is 3 further on
              win_col <= '0;
              win_row <= win_row + 5'd1;
              base    <= base + ADDR_W'(3);
            end else begin
              win_col <= win_col + 5'd1;
              base    <= base + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_window_reader.sv
module tb_cnn_window_reader;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int ADDR_W = 10;
  localparam int NWIN   = (IMG_W - 2) * (IMG_H - 2);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data;
  logic [8:0]        win;
  logic [4:0]        win_row;
  logic [4:0]        win_col;
  logic              win_valid;
  logic              win_ready;
  logic              busy;
  logic              done;

  logic mem [0:IMG_W*IMG_H-1];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] c;
    logic [8:0] w;
  } win_t;

  win_t sb[$];

  cnn_window_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_addr(rd_addr),
    .rd_data(rd_data), .win(win), .win_row(win_row), .win_col(win_col),
    .win_valid(win_valid), .win_ready(win_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM model with registered read port
  always @(posedge clk) rd_data <= mem[rd_addr];

  function automatic logic [8:0] exp_win(input int r, input int c);
    logic [8:0] w;
    for (int k = 0; k < 9; k++) w[k] = mem[(r + k / 3) * IMG_W + c + k % 3];
    return w;
  endfunction

  task automatic fill_image(input bit rnd);
    for (int i = 0; i < IMG_W * IMG_H; i++)
      mem[i] = rnd ? 1'($urandom_range(0, 1)) : 1'(((i / IMG_W) + (i % IMG_W)) % 2);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    win_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (rd_addr !== '0) begin n_err++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end
    n_cmp++; if (win !== 9'd0) begin n_err++; $display("FAIL reset_win got %b want 0", win); end
    n_cmp++; if (win_row !== 5'd0) begin n_err++; $display("FAIL reset_win_row got %0d want 0", win_row); end
    n_cmp++; if (win_col !== 5'd0) begin n_err++; $display("FAIL reset_win_col got %0d want 0", win_col); end
    n_cmp++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL reset_win_valid got %b want 0", win_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_without_start busy got %b want 0", busy); end
  endtask

  // Drives one complete scan with a scoreboard of all windows, checking the
  // address sequence of every window, optional stall on window (3,25),
  // optional start pulses during the scan, and the handshake/done timing.
  task automatic run_scan(input int stall_len, input bit pulse_starts);
    int n = 0;
    int hs = 0;
    int last_hs = -1;
    int done_n = -1;
    int done_cnt = 0;
    int stalled = 0;
    bit seen = 1'b0;
    bit addr_ok;
    int exp_a;
    logic [8:0] hw;
    logic [4:0] hr, hc;
    logic [ADDR_W-1:0] aq[$];
    win_t e;

    sb.delete();
    for (int r = 0; r < IMG_H - 2; r++)
      for (int c = 0; c < IMG_W - 2; c++)
        sb.push_back({5'(r), 5'(c), exp_win(r, c)});

    win_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_start got %b want 1", busy); end

    while (n < 9000 && !(done_cnt > 0 && n > done_n + 3)) begin
      if (pulse_starts) start = (n == 500 || n == 4000);
      if (done) begin done_cnt++; done_n = n; end
      if (busy && !win_valid) aq.push_back(rd_addr);
      if (win_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL extra_window got (%0d,%0d) want none", win_row, win_col);
          break;
        end
        e = sb[0];
        if (!seen) begin
          seen = 1'b1; hw = win; hr = win_row; hc = win_col;
          addr_ok = (aq.size() == 10);
          if (addr_ok) begin
            for (int k = 0; k < 9; k++) begin
              exp_a = (int'(e.r) + k / 3) * IMG_W + int'(e.c) + k % 3;
              if (aq[k] !== ADDR_W'(exp_a)) addr_ok = 1'b0;
            end
            if (aq[9] !== '0) addr_ok = 1'b0;
          end
          n_cmp++;
          if (!addr_ok) begin
            n_err++;
            $display("FAIL addr_seq window (%0d,%0d) got %0d reads first=%0d want 10 reads first=%0d",
                     e.r, e.c, aq.size(), (aq.size() > 0) ? aq[0] : 0, int'(e.r) * IMG_W + int'(e.c));
          end
          aq.delete();
        end else begin
          n_cmp++;
          if ({win, win_row, win_col} !== {hw, hr, hc}) begin
            n_err++;
            $display("FAIL window_hold got %b (%0d,%0d) want %b (%0d,%0d)", win, win_row, win_col, hw, hr, hc);
          end
        end
        if (stall_len > 0 && e.r == 5'd3 && e.c == 5'd25 && stalled < stall_len) begin
          win_ready = 1'b0;
          stalled++;
          n_cmp++;
          if (rd_addr !== '0) begin n_err++; $display("FAIL stall_rd_addr got %0d want 0", rd_addr); end
        end else begin
          win_ready = 1'b1;
          e = sb.pop_front();
          n_cmp++;
          if ({win_row, win_col, win} !== {e.r, e.c, e.w}) begin
            n_err++;
            $display("FAIL window_data got (%0d,%0d) %b want (%0d,%0d) %b", win_row, win_col, win, e.r, e.c, e.w);
          end
          hs++; last_hs = n + 1; seen = 1'b0;
        end
      end else begin
        win_ready = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;

    n_cmp++; if (hs !== NWIN) begin n_err++; $display("FAIL handshake_count got %0d want %0d", hs, NWIN); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL done_pulses got %0d want 1", done_cnt); end
    n_cmp++; if (last_hs !== 7436 + stall_len) begin n_err++; $display("FAIL last_handshake_edge got E0+%0d want E0+%0d", last_hs, 7436 + stall_len); end
    n_cmp++; if (done_n !== 7436 + stall_len) begin n_err++; $display("FAIL done_cycle got after E0+%0d want after E0+%0d", done_n, 7436 + stall_len); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_done got %b want 0", busy); end
    n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
  endtask

  task automatic test_full_scan;
    fill_image(1'b0);
    run_scan(0, 1'b1);
  endtask

  task automatic test_backpressure;
    fill_image(1'b1);
    run_scan(20, 1'b0);
  endtask

  task automatic test_abort;
    int n = 0;
    int hs = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    logic [8:0] w0;
    fill_image(1'b1);
    win_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (hs < 270 && n < 5000) begin
      if (win_valid) hs++;
      @(negedge clk); n++;
    end
    n_cmp++; if (hs !== 270) begin n_err++; $display("FAIL abort_reach got %0d handshakes want 270", hs); end
    n_cmp++;
    if ({win_row, win_col, rd_addr} !== {5'd10, 5'd10, ADDR_W'(290)}) begin
      n_err++;
      $display("FAIL abort_fetch_start got (%0d,%0d) addr %0d want (10,10) addr 290", win_row, win_col, rd_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rd_addr, win, win_row, win_col, win_valid, busy, done} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs got addr=%0d win=%b row=%0d col=%0d v=%b busy=%b done=%b want all 0",
               rd_addr, win, win_row, win_col, win_valid, busy, done);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL abort_no_done got %0d pulses want 0", done_cnt); end
    n_cmp++; if (busy_cnt !== 0) begin n_err++; $display("FAIL abort_idle got %0d busy cycles want 0", busy_cnt); end

    sb.delete();
    sb.push_back({5'd0, 5'd0, exp_win(0, 0)});
    win_ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!win_valid && n < 30) begin
      @(negedge clk); n++;
    end
    n_cmp++; if (n !== 10) begin n_err++; $display("FAIL restart_latency got E0+%0d want E0+10", n); end
    if (sb.size() > 0) begin
      w0 = sb[0].w;
      void'(sb.pop_front());
      n_cmp++;
      if ({win_valid, win_row, win_col, win} !== {1'b1, 5'd0, 5'd0, w0}) begin
        n_err++;
        $display("FAIL restart_window got v=%b (%0d,%0d) %b want v=1 (0,0) %b", win_valid, win_row, win_col, win, w0);
      end
    end
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    win_ready = 1'b0;
    fill_image(1'b0);
    test_reset;
    test_full_scan;
    test_backpressure;
    test_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
